// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the DRAM load/store port.
//   lsu_size_e  - access size encoding carried on req_size (11 is illegal)
//   lsu_state_e - sequencing FSM states of dram_lsu_port
//   SIZE_MASK_* - unshifted byte-lane masks per access size
//   size_mask() / is_misaligned() - small decode helpers
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } lsu_size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE0 = 3'd1,
    ST_WAIT0  = 3'd2,
    ST_ISSUE1 = 3'd3,
    ST_WAIT1  = 3'd4,
    ST_ERR    = 3'd5
  } lsu_state_e;

  localparam logic [3:0] SIZE_MASK_BYTE = 4'h1;
  localparam logic [3:0] SIZE_MASK_HALF = 4'h3;
  localparam logic [3:0] SIZE_MASK_WORD = 4'hF;

  // Illegal size yields an empty mask; such requests never reach memory.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (lsu_size_e'(size))
      SZ_BYTE: return SIZE_MASK_BYTE;
      SZ_HALF: return SIZE_MASK_HALF;
      SZ_WORD: return SIZE_MASK_WORD;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((lsu_size_e'(size) == SZ_HALF) && off[0]) ||
           ((lsu_size_e'(size) == SZ_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   Store side: st_size/st_off/st_wdata -> st_mask (8 lanes over two words)
//               and st_data (64-bit, low word first).
//   Load side:  {ld_hi, ld_lo} shifted down by ld_off bytes, then the low
//               8/16/32 bits sign- or zero-extended into ld_rdata.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [7:0]  st_mask,
  output logic [63:0] st_data,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_lo,
  input  logic [31:0] ld_hi,
  output logic [31:0] ld_rdata
);

  logic [31:0] ld_win;
  logic        ld_sign;

  assign st_mask = {4'h0, size_mask(st_size)} << st_off;
  assign st_data = {32'h0, st_wdata} << {st_off, 3'b000};

  // Bytes above the access size fall out of the window and are masked below.
  assign ld_win = 32'({ld_hi, ld_lo} >> {ld_off, 3'b000});
  assign ld_sign = ~ld_unsigned;

  // NOTE: every path through a combinational case assigns the output, so no latch.
  always_comb begin
    case (lsu_size_e'(ld_size))
      SZ_BYTE: ld_rdata = {{24{ld_sign & ld_win[7]}}, ld_win[7:0]};
      SZ_HALF: ld_rdata = {{16{ld_sign & ld_win[15]}}, ld_win[15:0]};
      default: ld_rdata = ld_win;
    endcase
  end

endmodule

// File: rtl/dram_lsu_port.sv
// dram_lsu_port: load/store initiator in front of a DRAM model with
// byte write enables and a one-cycle synchronous read.
//   req_*  - one access per req_valid && req_ready handshake (ready in IDLE)
//   rsp_*  - single-cycle response pulse with extended load data / error
//   mem_*  - registered DRAM address, byte enables, lane-positioned data;
//            mem_spo returns data one cycle after mem_a.
// Build option: define LSU_MISALIGN_SPLIT_EN to service misaligned accesses
// (split into two word accesses when they cross a word boundary); without it
// every misaligned access is answered with rsp_err.
module dram_lsu_port
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [3:0]            mem_we,
  output logic [31:0]           mem_din,
  input  logic [31:0]           mem_spo
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  lsu_state_e            state;
  logic                  accept;
  logic                  req_bad;
  logic [ADDR_WIDTH-1:0] req_word;
  logic                  unused_addr_hi;

  logic                  we_q, uns_q, cross_q;
  logic [1:0]            size_q, off_q;
  logic [ADDR_WIDTH-1:0] word_q;
  logic [3:0]            hi_mask_q;
  logic [31:0]           hi_data_q, lo_q;

  logic [7:0]            st_mask;
  logic [63:0]           st_data;
  logic [31:0]           ld_lo, ld_rdata;

  assign req_ready      = (state == ST_IDLE);
  assign accept         = req_valid && req_ready;
  assign req_word       = req_addr[ADDR_WIDTH+1:2];
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];
  assign req_bad        = (req_size == 2'b11) ||
                          (!SPLIT_EN && is_misaligned(req_size, req_addr[1:0]));

  // Second half of a split load pairs the captured low word with mem_spo.
  assign ld_lo = (state == ST_WAIT1) ? lo_q : mem_spo;

  lsu_lane_align u_align (
    .st_size     (req_size),
    .st_off      (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .st_mask     (st_mask),
    .st_data     (st_data),
    .ld_size     (size_q),
    .ld_off      (off_q),
    .ld_unsigned (uns_q),
    .ld_lo       (ld_lo),
    .ld_hi       (mem_spo),
    .ld_rdata    (ld_rdata)
  );

  // NOTE: captured request fields have no reset; they are always written at accept before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q      <= req_we;
      uns_q     <= req_unsigned;
      size_q    <= req_size;
      off_q     <= req_addr[1:0];
      word_q    <= req_word;
      cross_q   <= SPLIT_EN && (st_mask[7:4] != 4'h0);
      hi_mask_q <= st_mask[7:4];
      hi_data_q <= st_data[63:32];
    end
    if (state == ST_WAIT0) lo_q <= mem_spo;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_a     <= '0;
      mem_we    <= '0;
      mem_din   <= '0;
    end else begin
      // NOTE: defaults first make mem_we and rsp_valid single-cycle pulses.
      mem_we    <= '0;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_bad) begin
              state <= ST_ERR;
            end else begin
              state <= ST_ISSUE0;
              mem_a <= req_word;
              if (req_we) begin
                mem_we  <= st_mask[3:0];
                mem_din <= st_data[31:0];
              end
            end
          end
        end
        ST_ISSUE0: begin
          if (cross_q) begin
            mem_a <= word_q + ADDR_WIDTH'(1);
            if (we_q) begin
              mem_we  <= hi_mask_q;
              mem_din <= hi_data_q;
              state   <= ST_ISSUE1;
            end else begin
              state <= ST_WAIT0;
            end
          end else if (we_q) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end else begin
            state <= ST_WAIT0;
          end
        end
        ST_WAIT0: begin
          if (cross_q) begin
            state <= ST_WAIT1;
          end else begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b1;
            rsp_rdata <= ld_rdata;
            rsp_err   <= 1'b0;
          end
        end
        ST_ISSUE1: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        ST_WAIT1: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= ld_rdata;
          rsp_err   <= 1'b0;
        end
        ST_ERR: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_lsu_port.sv
// tb_dram_lsu_port: directed bench for dram_lsu_port with a behavioural
// DRAM (byte write enables, one-cycle synchronous read). Cycle numbers in
// the checks count from the accept cycle (cycle 0).
module tb_dram_lsu_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] mem_a;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_spo;

  logic [31:0] dram [0:65535];

  int checks = 0;
  int errors = 0;

  dram_lsu_port #(.ADDR_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_a        (mem_a),
    .mem_we       (mem_we),
    .mem_din      (mem_din),
    .mem_spo      (mem_spo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we[i]) dram[mem_a][8*i +: 8] <= mem_din[8*i +: 8];
    mem_spo <= dram[mem_a];
  end

  // Drives one request in the current cycle (cycle 0); returns in cycle 1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Advances until rsp_valid, bounded; returns the response cycle number.
  task automatic wait_rsp(input int start, output int cyc, output logic [31:0] rd, output logic er);
    cyc = start;
    while (rsp_valid !== 1'b1 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    rd = rsp_rdata; er = rsp_err;
  endtask

  task automatic store_word(input logic [31:0] addr, input logic [31:0] data);
    int c; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, addr, data);
    wait_rsp(1, c, rd, er);
  endtask

  task automatic load_check(input string name, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] exp);
    int c; logic [31:0] rd; logic er;
    issue(1'b0, size, uns, addr, 32'h0);
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 3) begin errors++; $display("FAIL %s_lat got %0d exp 3", name, c); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL %s_data got %h exp %h", name, rd, exp); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL %s_err got %b exp 0", name, er); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 65536; i++) dram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", rsp_err); end
    checks++; if (mem_a !== 16'h0) begin errors++; $display("FAIL rst_mem_a got %h exp 0", mem_a); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL rst_mem_we got %h exp 0", mem_we); end
    checks++; if (mem_din !== 32'h0) begin errors++; $display("FAIL rst_mem_din got %h exp 0", mem_din); end
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    int c; logic [31:0] rd; logic er;
    issue(1'b1, 2'b10, 1'b0, 32'h2000, 32'hDEADBEEF);
    checks++; if (mem_we !== 4'hF) begin errors++; $display("FAIL word_st_we got %h exp f", mem_we); end
    checks++; if (mem_a !== 16'h0800) begin errors++; $display("FAIL word_st_a got %h exp 0800", mem_a); end
    checks++; if (mem_din !== 32'hDEADBEEF) begin errors++; $display("FAIL word_st_din got %h exp deadbeef", mem_din); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 2) begin errors++; $display("FAIL word_st_lat got %0d exp 2", c); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL word_st_rsp got %h/%b exp 0/0", rd, er); end
    issue(1'b0, 2'b10, 1'b0, 32'h2000, 32'h0);
    checks++; if (mem_a !== 16'h0800 || mem_we !== 4'h0) begin errors++; $display("FAIL word_ld_issue got %h/%h exp 0800/0", mem_a, mem_we); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 3) begin errors++; $display("FAIL word_ld_lat got %0d exp 3", c); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL word_ld_data got %h exp deadbeef", rd); end
  endtask

  task automatic test_byte();
    int c; logic [31:0] rd; logic er;
    issue(1'b1, 2'b00, 1'b0, 32'h2003, 32'h00000080);
    checks++; if (mem_we !== 4'h8) begin errors++; $display("FAIL byte_st_we got %h exp 8", mem_we); end
    checks++; if (mem_din[31:24] !== 8'h80) begin errors++; $display("FAIL byte_st_din got %h exp 80xxxxxx", mem_din); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 2) begin errors++; $display("FAIL byte_st_lat got %0d exp 2", c); end
    load_check("byte_ld_s", 2'b00, 1'b0, 32'h2003, 32'hFFFFFF80);
    load_check("byte_ld_u", 2'b00, 1'b1, 32'h2003, 32'h00000080);
    load_check("byte_word", 2'b10, 1'b0, 32'h2000, 32'h80ADBEEF);
  endtask

  task automatic test_misalign();
    int c; logic [31:0] rd; logic er;
`ifdef LSU_MISALIGN_SPLIT_EN
    load_check("half_off1", 2'b01, 1'b0, 32'h2001, 32'hFFFFADBE);
`else
    issue(1'b0, 2'b01, 1'b0, 32'h2001, 32'h0);
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL mis_ld_we got %h exp 0", mem_we); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 2) begin errors++; $display("FAIL mis_ld_lat got %0d exp 2", c); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL mis_ld_rsp got %b/%h exp 1/0", er, rd); end
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL mis_ld_we2 got %h exp 0", mem_we); end
    issue(1'b1, 2'b10, 1'b0, 32'h2002, 32'h11111111);
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL mis_st_we got %h exp 0", mem_we); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 2 || er !== 1'b1) begin errors++; $display("FAIL mis_st_rsp got %0d/%b exp 2/1", c, er); end
    load_check("mis_st_kept", 2'b10, 1'b0, 32'h2000, 32'h80ADBEEF);
`endif
    issue(1'b0, 2'b11, 1'b0, 32'h2000, 32'h0);
    checks++; if (mem_we !== 4'h0) begin errors++; $display("FAIL size11_we got %h exp 0", mem_we); end
    wait_rsp(1, c, rd, er);
    checks++; if (c !== 2) begin errors++; $display("FAIL size11_lat got %0d exp 2", c); end
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size11_rsp got %b/%h exp 1/0", er, rd); end
  endtask

  task automatic test_split();
`ifdef LSU_MISALIGN_SPLIT_EN
    int c; logic [31:0] rd; logic er;
    store_word(32'h2000, 32'h44332211);
    store_word(32'h2004, 32'h88776655);
    issue(1'b0, 2'b10, 1'b0, 32'h2002, 32'h0);
    checks++; if (mem_a !== 16'h0800) begin errors++; $display("FAIL split_ld_a0 got %h exp 0800", mem_a); end
    @(posedge clk); #1;
    checks++; if (mem_a !== 16'h0801) begin errors++; $display("FAIL split_ld_a1 got %h exp 0801", mem_a); end
    wait_rsp(2, c, rd, er);
    checks++; if (c !== 4) begin errors++; $display("FAIL split_ld_lat got %0d exp 4", c); end
    checks++; if (rd !== 32'h66554433 || er !== 1'b0) begin errors++; $display("FAIL split_ld_data got %h/%b exp 66554433/0", rd, er); end
    issue(1'b1, 2'b10, 1'b0, 32'h2003, 32'hAABBCCDD);
    checks++; if (mem_we !== 4'h8 || mem_a !== 16'h0800 || mem_din[31:24] !== 8'hDD) begin errors++; $display("FAIL split_st_lo got %h/%h/%h exp 8/0800/ddxxxxxx", mem_we, mem_a, mem_din); end
    @(posedge clk); #1;
    checks++; if (mem_we !== 4'h7 || mem_a !== 16'h0801 || mem_din[23:0] !== 24'hAABBCC) begin errors++; $display("FAIL split_st_hi got %h/%h/%h exp 7/0801/xxaabbcc", mem_we, mem_a, mem_din); end
    wait_rsp(2, c, rd, er);
    checks++; if (c !== 3) begin errors++; $display("FAIL split_st_lat got %0d exp 3", c); end
    load_check("split_w0", 2'b10, 1'b0, 32'h2000, 32'hDD332211);
    load_check("split_w1", 2'b10, 1'b0, 32'h2004, 32'h88AABBCC);
`endif
  endtask

  task automatic test_back_to_back();
    int n_rsp, c1, c2; logic [31:0] d1, d2; logic rdy4;
    store_word(32'h3000, 32'h12345678);
    store_word(32'h3004, 32'h9ABCDEF0);
    n_rsp = 0; c1 = 0; c2 = 0; d1 = '0; d2 = '0; rdy4 = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h3000; req_wdata = '0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) req_addr = 32'h3004;
      if (cyc == 4) begin req_valid = 1'b0; rdy4 = req_ready; end
      if (rsp_valid === 1'b1) begin
        n_rsp++;
        if (n_rsp == 1) begin c1 = cyc; d1 = rsp_rdata; end
        else if (n_rsp == 2) begin c2 = cyc; d2 = rsp_rdata; end
      end
    end
    checks++; if (n_rsp !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n_rsp); end
    checks++; if (c1 !== 3 || d1 !== 32'h12345678) begin errors++; $display("FAIL b2b_first got %0d/%h exp 3/12345678", c1, d1); end
    checks++; if (rdy4 !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready %b exp 0", rdy4); end
    checks++; if (c2 !== 6 || d2 !== 32'h9ABCDEF0) begin errors++; $display("FAIL b2b_second got %0d/%h exp 6/9abcdef0", c2, d2); end
  endtask

  task automatic test_reset_mid();
    int n_rsp;
    issue(1'b0, 2'b10, 1'b0, 32'h3000, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_ld_rsp got %b exp 0", rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rmid_ld_ready got %b exp 1", req_ready); end
    n_rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid === 1'b1) n_rsp++;
    end
    checks++; if (n_rsp !== 0) begin errors++; $display("FAIL rmid_ld_late got %0d exp 0", n_rsp); end
    load_check("rmid_next", 2'b10, 1'b0, 32'h3004, 32'h9ABCDEF0);
    issue(1'b1, 2'b10, 1'b0, 32'h3008, 32'h0BADF00D);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++; if (mem_we !== 4'h0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rmid_st got %h/%b exp 0/0", mem_we, rsp_valid); end
    load_check("rmid_st_commit", 2'b10, 1'b0, 32'h3008, 32'h0BADF00D);
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_word();
    test_byte();
    test_misalign();
    test_split();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
